// File: rtl/conv_encoder_k3_if.sv
`default_nettype none
// =============================================================================
// conv_encoder_k3_if : bit-in / symbol-out handshake bundle for conv_encoder_k3
// Revision 1.0
// =============================================================================
interface conv_encoder_k3_if;
  logic       start;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sym;
  logic       out_last;
  logic [1:0] enc_state;
  logic       busy;

  // master: the environment feeding bits and draining symbols
  modport master (
    output start, in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_sym, out_last, enc_state, busy
  );

  // slave: the encoder itself
  modport slave (
    input  start, in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_sym, out_last, enc_state, busy
  );
endinterface
`default_nettype wire

// File: rtl/conv_encoder_k3.sv
`default_nettype none
// =============================================================================
// conv_encoder_k3 : framed rate-1/2 K=3 (7,5 octal) convolutional encoder
// Revision 1.0
// =============================================================================
module conv_encoder_k3 #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  conv_encoder_k3_if.slave enc_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [1:0]       sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tail2_q, tail2_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_sym_q, out_sym_d;
  logic             out_last_q, out_last_d;

  logic             w_slot_free;
  logic             w_in_ready;
  logic             w_enc_en;
  logic             w_enc_u;

  // The output register can take a new symbol when empty or draining this cycle.
  assign w_slot_free = !out_valid_q || enc_if.out_ready;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    tail2_d     = tail2_q;
    out_valid_d = out_valid_q;
    out_sym_d   = out_sym_q;
    out_last_d  = out_last_q;
    w_in_ready  = 1'b0;
    w_enc_en    = 1'b0;
    w_enc_u     = 1'b0;

    case (state_q)
      IDLE: begin
        if (enc_if.start) begin
          state_d = DATA;
          sr_d    = 2'b00;
          cnt_d   = '0;
        end
      end
      DATA: begin
        w_in_ready = w_slot_free;
        if (enc_if.in_valid && w_slot_free) begin
          w_enc_en = 1'b1;
          w_enc_u  = enc_if.in_bit;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = TAIL;
            tail2_d = 1'b0;
          end
        end
      end
      TAIL: begin
        if (w_slot_free) begin
          w_enc_en = 1'b1;
          tail2_d  = 1'b1;
          if (tail2_q) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Shared encode path for data and tail bits; tail bits have w_enc_u = 0.
    if (w_enc_en) begin
      sr_d        = {w_enc_u, sr_q[1]};
      out_valid_d = 1'b1;
      out_sym_d   = {w_enc_u ^ sr_q[1] ^ sr_q[0], w_enc_u ^ sr_q[0]};
      out_last_d  = (state_q == TAIL) && tail2_q;
    end else if (enc_if.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= 2'b00;
      cnt_q       <= '0;
      tail2_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sym_q   <= 2'b00;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      tail2_q     <= tail2_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_last_q  <= out_last_d;
    end
  end

  assign enc_if.in_ready  = w_in_ready;
  assign enc_if.out_valid = out_valid_q;
  assign enc_if.out_sym   = out_sym_q;
  assign enc_if.out_last  = out_last_q;
  assign enc_if.enc_state = sr_q;
  assign enc_if.busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/conv_encoder_k3.md
CONV_ENCODER_K3 -- requirements
Module: conv_encoder_k3

Interface
REQ-001 SHALL provide parameter FRAME_LEN, default 16, meaning data bits per frame (legal 1..255).
REQ-002 SHALL provide parameter CNT_W, default 8, meaning width of the internal bit counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, begin-frame pulse; sampled only in IDLE.
REQ-007 SHALL have port in_valid, input, 1, in_bit qualifier.
REQ-008 SHALL have port in_bit, input, 1, information bit u.
REQ-009 SHALL have port in_ready, output, 1, encoder accepts in_bit this cycle.
REQ-010 SHALL have port out_valid, output, 1, out_sym holds a valid symbol.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts out_sym.
REQ-012 SHALL have port out_sym, output, 2, coded symbol {c1,c0}.
REQ-013 SHALL have port out_last, output, 1, out_sym is the final tail symbol of the frame.
REQ-014 SHALL have port enc_state, output, 2, current shift-register state sr[1:0] (0..3).
REQ-015 SHALL have port busy, output, 1, FSM not in IDLE.

Function
REQ-016 SHALL implement a rate-1/2, K=3 code with generators 7 and 5 (octal): c1 = u^sr[1]^sr[0], c0 = u^sr[0].
REQ-017 SHALL update sr <= {u, sr[1]} on every encoded bit, data or tail.
REQ-018 SHALL implement FSM states IDLE, DATA and TAIL.
REQ-019 IDLE: in_ready=0; start=1 -> DATA, sr cleared to 0, bit counter cleared to 0.
REQ-020 DATA: in_ready = !out_valid || out_ready; a bit is accepted when in_valid && in_ready.
REQ-021 DATA: the accepted bit that brings the count to FRAME_LEN SHALL be the last data bit; FSM -> TAIL next cycle.
REQ-022 TAIL: in_ready=0; two zero-input tail bits SHALL be encoded, each when the output slot is free (!out_valid || out_ready).
REQ-023 TAIL: the second tail symbol SHALL be loaded with out_last=1; FSM -> IDLE in the same cycle, leaving sr=0.
REQ-024 Output register: out_sym/out_last SHALL be loaded the cycle after acceptance (latency 1 clock); out_valid is set on load and cleared when out_ready=1 with no new load.
REQ-025 out_sym/out_last SHALL hold stable while out_valid=1 && out_ready=0.
REQ-026 SHALL support simultaneous drain and load: out_ready=1 plus a new encode in the same cycle keeps out_valid=1 with the new symbol, giving full throughput of one symbol per clock.
REQ-027 SHALL ignore start outside IDLE, and SHALL ignore in_valid in IDLE and TAIL.
REQ-028 FRAME_LEN=1 SHALL produce exactly 3 symbols (1 data + 2 tail).
REQ-029 busy SHALL be 1 in DATA and TAIL, and 0 in IDLE, including while the final symbol waits in the output register.
REQ-030 enc_state SHALL equal sr at all times.

Reset
REQ-031 rst_n=0 SHALL, asynchronously: FSM=IDLE, sr=0, counter=0, out_valid=0, out_sym=0, out_last=0, in_ready=0, busy=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no tail and no out_last; the first frame after reset requires a new start.

Verification
REQ-033 FRAME_LEN=4, start, bits 1,0,1,1 with out_ready=1 -> out_sym 11,10,00,01,01,11 on consecutive valid cycles, out_last only on the 6th symbol, enc_state 0 afterwards.
REQ-034 Same frame with out_ready toggled 1,0,1,0,... -> identical symbol sequence, no drops or duplicates, out_sym stable during stalls, in_ready=0 while a stalled symbol is held.
REQ-035 FRAME_LEN=1, bit 1 -> symbols 11,10,11 with out_last on the third; busy falls the cycle after the last load.
REQ-036 start pulsed during DATA and in_valid asserted during TAIL/IDLE -> no effect on symbol count (FRAME_LEN+2) or values.
REQ-037 rst_n asserted after 2 of 4 data bits -> out_valid=0 and busy=0 immediately; next start plus 1,0,1,1 -> 11,10,00,01,01,11.
REQ-038 Random frames with random valid/ready -> scoreboard against the reference encoder equation; each frame yields FRAME_LEN+2 symbols, exactly one out_last, and a final state of 0.
